mem_req_bridge: RTL and testbench

Multi-channel bridge between byte-wide CPU/peripheral bus masters and the 16-bit toggle-handshake port of `sdram`. It turns level-style `cs`/`oe`/`we` bus activity into single memory requests using edge and address-change detection, and arbitrates channels round-robin onto one `sdram` port. It also maps bytes onto word lanes, returns read bytes per channel, and optionally serves repeated reads from a per-channel word cache. It sits between the machine core(s) and `sdram` in the MiST top level, all in the `sdram` clock domain.

---
 rtl/mem_req_bridge.sv | 150 +++++++++++++++
 tb/tb_mem_req_bridge.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_req_bridge.sv
// mem_req_bridge: edge-triggered byte bus masters onto one round-robin toggle-handshake sdram port
module mem_req_bridge #(
  parameter int NCH = 2,
  parameter int AW = 16,
  parameter bit RD_CACHE = 1'b1
) (
  input  logic              clk,
  input  logic              init_n,
  input  logic [NCH-1:0]    ch_cs,
  input  logic [NCH-1:0]    ch_oe,
  input  logic [NCH-1:0]    ch_we,
  input  logic [NCH*AW-1:0] ch_addr,
  input  logic [NCH*8-1:0]  ch_d,
  output logic [NCH*8-1:0]  ch_q,
  output logic [NCH-1:0]    ch_busy,
  output logic [NCH-1:0]    ch_ovr,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [AW-2:0]     mem_a,
  output logic [1:0]        mem_ds,
  output logic              mem_we,
  output logic [15:0]       mem_d,
  input  logic [15:0]       mem_q
);
  localparam int GW = NCH > 1 ? $clog2(NCH) : 1;
  typedef enum logic {A_IDLE, A_WAIT} state_t;
  state_t state, state_nx;
  logic [NCH-1:0] prev_rd, prev_wr, pend_v, pend_we, fl_v, fl_we, c_v, hit_v;
  logic [NCH-1:0] wr_start, rd_start, hit, trig;
  logic [AW-1:0] addr [NCH];
  logic [AW-1:0] prev_addr [NCH];
  logic [AW-1:0] pend_a [NCH];
  logic [AW-1:0] fl_a [NCH];
  logic [7:0] pend_d [NCH];
  logic [7:0] q [NCH];
  logic [7:0] hit_b [NCH];
  logic [AW-2:0] c_a [NCH];
  logic [15:0] c_d [NCH];
  logic [GW-1:0] last_g, cur_g, gnt;
  logic gnt_v, done;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign addr[g] = ch_addr[g*AW +: AW];
    assign ch_q[g*8 +: 8] = q[g];
  end

  assign ch_busy = pend_v | fl_v;

  // per-channel write-edge / read-edge-or-address-change triggers and cache lookup
  always_comb begin
    rd_start = '0;
    hit = '0;
    wr_start = ch_cs & ch_we & ~prev_wr;
    for (int i = 0; i < NCH; i++) begin
      rd_start[i] = ch_cs[i] & ch_oe[i] & (~prev_rd[i] | (addr[i] != prev_addr[i])) & ~wr_start[i];
      hit[i] = RD_CACHE & rd_start[i] & c_v[i] & (c_a[i] == addr[i][AW-1:1]);
    end
    trig = wr_start | (rd_start & ~hit);
  end

  // round-robin pick starting after the last grant, and arbiter next state
  always_comb begin
    gnt = '0;
    gnt_v = 1'b0;
    done = (state == A_WAIT) && (mem_ack == mem_req);
    state_nx = state;
    if (state == A_IDLE && mem_ack == mem_req)
      for (int k = NCH; k >= 1; k--)
        if (pend_v[(int'(last_g) + k) % NCH] && !fl_v[(int'(last_g) + k) % NCH]) begin
          gnt = GW'((int'(last_g) + k) % NCH);
          gnt_v = 1'b1;
        end
    state_nx = gnt_v ? A_WAIT : done ? A_IDLE : state;
  end

  // slots, cache, memory port registers and edge history
  always_ff @(posedge clk) begin
    if (!init_n) begin
      state <= A_IDLE;
      mem_req <= 1'b0;
      mem_a <= '0;
      mem_ds <= 2'b11;
      mem_we <= 1'b0;
      mem_d <= '0;
      last_g <= GW'(NCH - 1);
      cur_g <= '0;
      prev_rd <= '0;
      prev_wr <= '0;
      pend_v <= '0;
      pend_we <= '0;
      fl_v <= '0;
      fl_we <= '0;
      c_v <= '0;
      hit_v <= '0;
      ch_ovr <= '0;
      for (int i = 0; i < NCH; i++) begin
        prev_addr[i] <= '0;
        pend_a[i] <= '0;
        fl_a[i] <= '0;
        pend_d[i] <= '0;
        q[i] <= '0;
        hit_b[i] <= '0;
        c_a[i] <= '0;
        c_d[i] <= '0;
      end
    end else begin
      state <= state_nx;
      prev_rd <= ch_cs & ch_oe;
      prev_wr <= ch_cs & ch_we;
      if (gnt_v) begin
        last_g <= gnt;
        cur_g <= gnt;
        mem_req <= ~mem_req;
        mem_a <= pend_a[gnt][AW-1:1];
        mem_we <= pend_we[gnt];
        mem_d <= {2{pend_d[gnt]}};
        mem_ds <= pend_we[gnt] ? (pend_a[gnt][0] ? 2'b10 : 2'b01) : 2'b11;
        fl_v[gnt] <= 1'b1;
        fl_a[gnt] <= pend_a[gnt];
        fl_we[gnt] <= pend_we[gnt];
        pend_v[gnt] <= 1'b0;
        if (pend_we[gnt])
          for (int i = 0; i < NCH; i++)
            if (c_a[i] == pend_a[gnt][AW-1:1]) c_v[i] <= 1'b0;
      end
      if (done) begin
        fl_v[cur_g] <= 1'b0;
        if (!fl_we[cur_g]) begin
          q[cur_g] <= fl_a[cur_g][0] ? mem_q[15:8] : mem_q[7:0];
          c_v[cur_g] <= RD_CACHE;
          c_a[cur_g] <= fl_a[cur_g][AW-1:1];
          c_d[cur_g] <= mem_q;
        end
      end
      for (int i = 0; i < NCH; i++) begin
        prev_addr[i] <= addr[i];
        hit_v[i] <= hit[i];
        hit_b[i] <= addr[i][0] ? c_d[i][15:8] : c_d[i][7:0];
        if (hit_v[i]) q[i] <= hit_b[i];
        if (trig[i]) begin
          pend_v[i] <= 1'b1;
          pend_a[i] <= addr[i];
          pend_we[i] <= wr_start[i];
          pend_d[i] <= ch_d[i*8 +: 8];
          if (pend_v[i] && !(gnt_v && gnt == GW'(i))) ch_ovr[i] <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_req_bridge.sv
// tb_mem_req_bridge: directed scenario tests for mem_req_bridge
module tb_mem_req_bridge;
  logic clk = 1'b0;
  logic init_n = 1'b0;
  logic [1:0] ch_cs = '0;
  logic [1:0] ch_oe = '0;
  logic [1:0] ch_we = '0;
  logic [31:0] ch_addr = '0;
  logic [15:0] ch_d = '0;
  logic [15:0] ch_q;
  logic [1:0] ch_busy;
  logic [1:0] ch_ovr;
  logic mem_req;
  logic mem_ack = 1'b0;
  logic [14:0] mem_a;
  logic [1:0] mem_ds;
  logic mem_we;
  logic [15:0] mem_d;
  logic [15:0] mem_q = '0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_req_bridge #(.NCH(2), .AW(16), .RD_CACHE(1'b1)) dut (
    .clk(clk), .init_n(init_n), .ch_cs(ch_cs), .ch_oe(ch_oe), .ch_we(ch_we),
    .ch_addr(ch_addr), .ch_d(ch_d), .ch_q(ch_q), .ch_busy(ch_busy), .ch_ovr(ch_ovr),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_a(mem_a), .mem_ds(mem_ds),
    .mem_we(mem_we), .mem_d(mem_d), .mem_q(mem_q)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    init_n = 1'b0;
    tick();
    tick();
    tests++; if ({mem_req, mem_we, mem_ds} !== 4'b0011) begin fails++; $display("FAIL reset_ctl got %b exp 0011", {mem_req, mem_we, mem_ds}); end
    tests++; if ({mem_a, mem_d} !== 31'h0) begin fails++; $display("FAIL reset_addr_data got %h exp 0", {mem_a, mem_d}); end
    tests++; if ({ch_q, ch_busy, ch_ovr} !== 20'h0) begin fails++; $display("FAIL reset_ch got %h exp 0", {ch_q, ch_busy, ch_ovr}); end
    init_n = 1'b1;
    tick();
  endtask

  task automatic test_read();
    ch_addr[15:0] = 16'h1235; ch_cs[0] = 1'b1; ch_oe[0] = 1'b1;
    tick();
    tests++; if ({ch_busy[0], mem_req} !== 2'b10) begin fails++; $display("FAIL rd_pend got %b exp 10", {ch_busy[0], mem_req}); end
    tick();
    tests++; if ({mem_req, mem_we, mem_ds} !== 4'b1011) begin fails++; $display("FAIL rd_issue_ctl got %b exp 1011", {mem_req, mem_we, mem_ds}); end
    tests++; if (mem_a !== 15'h091A) begin fails++; $display("FAIL rd_issue_a got %h exp 091a", mem_a); end
    ch_cs[0] = 1'b0; ch_oe[0] = 1'b0;
    tick(); tick(); tick();
    tests++; if ({ch_busy[0], ch_q[7:0]} !== 9'h100) begin fails++; $display("FAIL rd_wait got %h exp 100", {ch_busy[0], ch_q[7:0]}); end
    mem_q = 16'hBEEF; mem_ack = 1'b1;
    tick();
    tests++; if (ch_q !== 16'h00BE) begin fails++; $display("FAIL rd_done_q got %h exp 00be", ch_q); end
    tests++; if (ch_busy !== 2'b00) begin fails++; $display("FAIL rd_done_busy got %b exp 00", ch_busy); end
  endtask

  task automatic test_write();
    ch_addr[31:16] = 16'h0010; ch_d[15:8] = 8'hA5; ch_cs[1] = 1'b1; ch_we[1] = 1'b1;
    tick();
    tests++; if (ch_busy[1] !== 1'b1) begin fails++; $display("FAIL wr_pend got %b exp 1", ch_busy[1]); end
    tick();
    tests++; if ({mem_req, mem_we, mem_ds} !== 4'b0101) begin fails++; $display("FAIL wr_issue_ctl got %b exp 0101", {mem_req, mem_we, mem_ds}); end
    tests++; if ({mem_a, mem_d} !== {15'h0008, 16'hA5A5}) begin fails++; $display("FAIL wr_issue_ad got %h/%h exp 0008/a5a5", mem_a, mem_d); end
    ch_cs[1] = 1'b0; ch_we[1] = 1'b0; mem_ack = 1'b0;
    tick();
    tests++; if ({ch_busy[1], ch_q[15:8]} !== 9'h000) begin fails++; $display("FAIL wr_done got %h exp 000", {ch_busy[1], ch_q[15:8]}); end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 4; r++) begin
      ch_addr = {16'h0200, 16'h0100}; ch_d = {8'(8'h20 + r), 8'(8'h10 + r)};
      ch_cs = 2'b11; ch_we = 2'b11;
      tick();
      ch_cs = 2'b00; ch_we = 2'b00;
      for (int g = 0; g < 2; g++) begin
        logic prev;
        prev = mem_req;
        tick();
        tests++; if (mem_req === prev) begin fails++; $display("FAIL arb_toggle r%0d g%0d got %b exp %b", r, g, mem_req, ~prev); end
        tests++; if ({mem_a, mem_d} !== {(g == 1) ? 15'h0100 : 15'h0080, {2{ch_d[g*8 +: 8]}}}) begin fails++; $display("FAIL arb_grant r%0d g%0d got %h/%h", r, g, mem_a, mem_d); end
        mem_ack = mem_req;
        tick();
        tests++; if ({mem_req === mem_ack, ch_busy[g]} !== 2'b10) begin fails++; $display("FAIL arb_gap r%0d g%0d got %b exp 10", r, g, {mem_req === mem_ack, ch_busy[g]}); end
      end
    end
  endtask

  task automatic test_cache();
    ch_addr[15:0] = 16'h2000; ch_cs[0] = 1'b1; ch_oe[0] = 1'b1;
    tick(); tick();
    tests++; if ({mem_req, mem_a} !== {1'b1, 15'h1000}) begin fails++; $display("FAIL cache_miss_issue got %h exp 9000", {mem_req, mem_a}); end
    ch_cs[0] = 1'b0; ch_oe[0] = 1'b0; mem_q = 16'h3C7E; mem_ack = 1'b1;
    tick();
    tests++; if (ch_q[7:0] !== 8'h7E) begin fails++; $display("FAIL cache_miss_q got %h exp 7e", ch_q[7:0]); end
    mem_q = 16'h0000;
    ch_addr[15:0] = 16'h2001; ch_cs[0] = 1'b1; ch_oe[0] = 1'b1;
    tick();
    tests++; if ({ch_busy[0], ch_q[7:0]} !== 9'h07E) begin fails++; $display("FAIL cache_hit_k got %h exp 07e", {ch_busy[0], ch_q[7:0]}); end
    tick();
    tests++; if (ch_q[7:0] !== 8'h3C) begin fails++; $display("FAIL cache_hit_q got %h exp 3c", ch_q[7:0]); end
    tests++; if ({mem_req, ch_busy[0]} !== 2'b10) begin fails++; $display("FAIL cache_hit_noreq got %b exp 10", {mem_req, ch_busy[0]}); end
    ch_cs[0] = 1'b0; ch_oe[0] = 1'b0;
    ch_addr[31:16] = 16'h2001; ch_d[15:8] = 8'h11; ch_cs[1] = 1'b1; ch_we[1] = 1'b1;
    tick(); tick();
    tests++; if ({mem_req, mem_ds, mem_d} !== {1'b0, 2'b10, 16'h1111}) begin fails++; $display("FAIL cache_wr_issue got %b/%b/%h exp 0/10/1111", mem_req, mem_ds, mem_d); end
    ch_cs[1] = 1'b0; ch_we[1] = 1'b0; mem_ack = 1'b0;
    tick();
    ch_addr[15:0] = 16'h2000; ch_cs[0] = 1'b1; ch_oe[0] = 1'b1;
    tick();
    tests++; if (ch_busy[0] !== 1'b1) begin fails++; $display("FAIL cache_inval_busy got %b exp 1", ch_busy[0]); end
    tick();
    tests++; if ({mem_req, mem_a} !== {1'b1, 15'h1000}) begin fails++; $display("FAIL cache_inval_issue got %h exp 9000", {mem_req, mem_a}); end
    ch_cs[0] = 1'b0; ch_oe[0] = 1'b0; mem_q = 16'h9912; mem_ack = 1'b1;
    tick();
    tests++; if (ch_q[7:0] !== 8'h12) begin fails++; $display("FAIL cache_inval_q got %h exp 12", ch_q[7:0]); end
  endtask

  task automatic test_overwrite();
    ch_addr[15:0] = 16'h0300; ch_d[7:0] = 8'h01; ch_cs[0] = 1'b1; ch_we[0] = 1'b1;
    tick();
    ch_cs[0] = 1'b0; ch_we[0] = 1'b0;
    tick();
    tests++; if ({mem_req, mem_a} !== {1'b0, 15'h0180}) begin fails++; $display("FAIL ovr_first got %h exp 0180", {mem_req, mem_a}); end
    ch_addr[15:0] = 16'h0302; ch_d[7:0] = 8'h02; ch_cs[0] = 1'b1; ch_we[0] = 1'b1;
    tick();
    ch_cs[0] = 1'b0; ch_we[0] = 1'b0;
    tick();
    tests++; if ({ch_ovr[0], ch_busy[0]} !== 2'b01) begin fails++; $display("FAIL ovr_second got %b exp 01", {ch_ovr[0], ch_busy[0]}); end
    ch_addr[15:0] = 16'h0304; ch_d[7:0] = 8'h03; ch_cs[0] = 1'b1; ch_we[0] = 1'b1;
    tick();
    ch_cs[0] = 1'b0; ch_we[0] = 1'b0;
    tests++; if (ch_ovr[0] !== 1'b1) begin fails++; $display("FAIL ovr_third got %b exp 1", ch_ovr[0]); end
    mem_ack = 1'b0;
    tick(); tick();
    tests++; if ({mem_req, mem_a, mem_d, mem_ds} !== {1'b1, 15'h0182, 16'h0303, 2'b01}) begin fails++; $display("FAIL ovr_issue got %b/%h/%h/%b exp 1/0182/0303/01", mem_req, mem_a, mem_d, mem_ds); end
    mem_ack = 1'b1;
    tick(); tick(); tick();
    tests++; if ({mem_req, ch_busy[0], ch_ovr[0]} !== 3'b101) begin fails++; $display("FAIL ovr_single got %b exp 101", {mem_req, ch_busy[0], ch_ovr[0]}); end
  endtask

  task automatic test_reset_mid();
    ch_addr[31:16] = 16'h0400; ch_cs[1] = 1'b1; ch_oe[1] = 1'b1;
    tick();
    ch_cs[1] = 1'b0; ch_oe[1] = 1'b0;
    tick();
    tests++; if ({mem_req, ch_busy[1]} !== 2'b01) begin fails++; $display("FAIL rstm_issue got %b exp 01", {mem_req, ch_busy[1]}); end
    tick();
    init_n = 1'b0;
    tick();
    tests++; if ({mem_req, mem_we, mem_ds} !== 4'b0011) begin fails++; $display("FAIL rstm_ctl got %b exp 0011", {mem_req, mem_we, mem_ds}); end
    tests++; if ({mem_a, mem_d} !== 31'h0) begin fails++; $display("FAIL rstm_ad got %h exp 0", {mem_a, mem_d}); end
    tests++; if ({ch_q, ch_busy, ch_ovr} !== 20'h0) begin fails++; $display("FAIL rstm_ch got %h exp 0", {ch_q, ch_busy, ch_ovr}); end
    init_n = 1'b1;
    ch_addr[15:0] = 16'h0500; ch_d[7:0] = 8'h55; ch_cs[0] = 1'b1; ch_we[0] = 1'b1;
    tick();
    ch_cs[0] = 1'b0; ch_we[0] = 1'b0;
    tests++; if (ch_busy[0] !== 1'b1) begin fails++; $display("FAIL rstm_pend got %b exp 1", ch_busy[0]); end
    tick(); tick(); tick();
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rstm_hold got %b exp 0", mem_req); end
    mem_ack = 1'b0;
    tick();
    tests++; if ({mem_req, mem_a, mem_d} !== {1'b1, 15'h0280, 16'h5555}) begin fails++; $display("FAIL rstm_reissue got %b/%h/%h exp 1/0280/5555", mem_req, mem_a, mem_d); end
    mem_ack = 1'b1;
    tick();
    tests++; if (ch_busy !== 2'b00) begin fails++; $display("FAIL rstm_done got %b exp 00", ch_busy); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_cache();
    test_overwrite();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
